// File: rtl/tinyqv_instr_buffer.sv
// tinyqv_instr_buffer: halfword prefetch ring that assembles instructions at pc.
// Define TINYQV_IBUF_RVC_EN to support 16-bit compressed instructions.
module tinyqv_instr_buffer #(
    parameter int                 DEPTH      = 4,
    parameter int                 PC_BITS    = 24,
    parameter logic [PC_BITS-1:0] RESET_ADDR = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [15:0]        fetch_data,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    output logic [PC_BITS-1:0] fetch_addr,
    output logic               fetch_restart,
    output logic [31:0]        instr,
    output logic [1:0]         instr_len,
    output logic               instr_valid,
    output logic [PC_BITS-1:0] pc,
    input  logic               instr_complete,
    input  logic               branch,
    input  logic [PC_BITS-1:0] branch_target
);

    localparam int IW = $clog2(DEPTH);
    localparam int AW = IW + 1;

`ifdef TINYQV_IBUF_RVC_EN
    localparam logic [PC_BITS-1:0] ALIGN = ~PC_BITS'(1);
`else
    localparam logic [PC_BITS-1:0] ALIGN = ~PC_BITS'(3);
`endif

    localparam logic [PC_BITS-1:0] RST_PC = RESET_ADDR & ALIGN;

    logic [15:0]        hw [DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [AW-1:0]      count;
    logic [IW-1:0]      ridx;
    logic [IW-1:0]      ridx1;
    logic [15:0]        lo_hw;
    logic [15:0]        hi_hw;
    logic [PC_BITS-1:0] target;
    logic               push;
    logic               pop;

    assign count = wptr - rptr;
    assign ridx  = rptr[IW-1:0];
    assign ridx1 = ridx + IW'(1);

    // Empty slots read as zero so a drained buffer presents instr = 0
    assign lo_hw = (count != '0) ? hw[ridx] : 16'h0000;
    assign hi_hw = (count >= AW'(2)) ? hw[ridx1] : 16'h0000;
    assign instr = {hi_hw, lo_hw};

`ifdef TINYQV_IBUF_RVC_EN
    assign instr_len = (lo_hw[1:0] == 2'b11) ? 2'd2 : 2'd1;
`else
    assign instr_len = 2'd2;
`endif

    assign instr_valid = (count >= AW'(instr_len));
    assign fetch_ready = (count < AW'(DEPTH));

    // Data landing while the restart pulse is high belongs to the old stream
    assign push   = fetch_valid && fetch_ready && !fetch_restart && !branch;
    assign pop    = instr_complete && instr_valid && !branch;
    assign target = branch_target & ALIGN;

    // Halfword storage; contents are only meaningful between rptr and wptr
    always_ff @(posedge clk) begin
        if (push) begin
            hw[wptr[IW-1:0]] <= fetch_data;
        end
    end

    // Pointers, pc and fetch address; a branch overrides push and pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr          <= '0;
            rptr          <= '0;
            pc            <= RST_PC;
            fetch_addr    <= RST_PC;
            fetch_restart <= 1'b0;
        end else begin
            fetch_restart <= branch;
            if (branch) begin
                rptr       <= wptr;
                pc         <= target;
                fetch_addr <= target;
            end else begin
                if (push) begin
                    wptr       <= wptr + AW'(1);
                    fetch_addr <= fetch_addr + PC_BITS'(2);
                end
                if (pop) begin
                    rptr <= rptr + AW'(instr_len);
                    pc   <= pc + PC_BITS'({instr_len, 1'b0});
                end
            end
        end
    end

endmodule

// File: tb/tb_tinyqv_instr_buffer.sv
// tb_tinyqv_instr_buffer: directed vector bench for tinyqv_instr_buffer.
// Covers fill/drain, full stall, branch flush, wrap and async reset.
module tb_tinyqv_instr_buffer;

`ifdef TINYQV_IBUF_RVC_EN
    localparam logic [1:0] EMPTY_LEN = 2'd1;
`else
    localparam logic [1:0] EMPTY_LEN = 2'd2;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] fetch_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [23:0] fetch_addr;
    logic        fetch_restart;
    logic [31:0] instr;
    logic [1:0]  instr_len;
    logic        instr_valid;
    logic [23:0] pc;
    logic        instr_complete;
    logic        branch;
    logic [23:0] branch_target;

    int checks   = 0;
    int failures = 0;

    tinyqv_instr_buffer #(
        .DEPTH(4),
        .PC_BITS(24),
        .RESET_ADDR(24'h000000)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .fetch_data(fetch_data),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_addr(fetch_addr),
        .fetch_restart(fetch_restart),
        .instr(instr),
        .instr_len(instr_len),
        .instr_valid(instr_valid),
        .pc(pc),
        .instr_complete(instr_complete),
        .branch(branch),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [15:0] fd;
        logic        ic;
        logic        br;
        logic [23:0] bt;
        logic        ev;
        logic [31:0] ei;
        logic [1:0]  el;
        logic [23:0] epc;
        logic [23:0] efa;
        logic        erdy;
        logic        ers;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic fv, input logic [15:0] fd, input logic ic,
        input logic br, input logic [23:0] bt,
        input logic ev, input logic [31:0] ei, input logic [1:0] el,
        input logic [23:0] epc, input logic [23:0] efa,
        input logic erdy, input logic ers);
        vec_t v;
        v.fv = fv; v.fd = fd; v.ic = ic; v.br = br; v.bt = bt;
        v.ev = ev; v.ei = ei;
        v.el = (el == 2'd0) ? EMPTY_LEN : el;
        v.epc = epc; v.efa = efa; v.erdy = erdy; v.ers = ers;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, 32'(pc), 32'h0);
        chk({tag, "_faddr"}, 32'(fetch_addr), 32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_len"}, 32'(instr_len), 32'(EMPTY_LEN));
        chk({tag, "_ready"}, 32'(fetch_ready), 32'h1);
        chk({tag, "_restart"}, 32'(fetch_restart), 32'h0);
    endtask

    function automatic logic [31:0] stream_instr(input int k);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'((k << 7) | 32'h13);
        hi = 16'(k + 32'h100);
        return {hi, lo};
    endfunction

    initial begin
        logic [23:0] exp_pc;
        logic [31:0] w;
        int          sent;
        int          got;
        int          n;

        rstn           = 1'b0;
        fetch_data     = '0;
        fetch_valid    = 1'b0;
        instr_complete = 1'b0;
        branch         = 1'b0;
        branch_target  = '0;
        #1;
        chk_reset_state("reset");
        #1 rstn = 1'b1;

        // fv fd ic br bt | valid instr len(0=empty) pc faddr ready restart
        tbl.push_back(mk(1, 16'h0013, 0, 0, 0, 0, 32'h00000013, 2, 24'h0, 24'h2, 1, 0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 32'h00000013, 2, 24'h0, 24'h4, 1, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 32'h00000000, 0, 24'h4, 24'h4, 1, 0));
        tbl.push_back(mk(1, 16'h0513, 0, 0, 0, 0, 32'h00000513, 2, 24'h4, 24'h6, 1, 0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 32'h00000513, 2, 24'h4, 24'h8, 1, 0));
        tbl.push_back(mk(1, 16'h00b3, 0, 0, 0, 1, 32'h00000513, 2, 24'h4, 24'ha, 1, 0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 32'h00000513, 2, 24'h4, 24'hc, 0, 0));
        tbl.push_back(mk(1, 16'h1234, 0, 0, 0, 1, 32'h00000513, 2, 24'h4, 24'hc, 0, 0));
        tbl.push_back(mk(1, 16'h5555, 1, 0, 0, 1, 32'h000000b3, 2, 24'h8, 24'hc, 1, 0));
        tbl.push_back(mk(1, 16'h0093, 1, 0, 0, 0, 32'h00000093, 2, 24'hc, 24'he, 1, 0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 32'h00000093, 2, 24'hc, 24'h10, 1, 0));
        tbl.push_back(mk(1, 16'h0013, 0, 0, 0, 1, 32'h00000093, 2, 24'hc, 24'h12, 1, 0));
        tbl.push_back(mk(1, 16'h0113, 1, 1, 24'h000101,
                         0, 32'h0, 0, 24'h100, 24'h100, 1, 1));
        tbl.push_back(mk(1, 16'hdead, 0, 0, 0, 0, 32'h0, 0, 24'h100, 24'h100, 1, 0));
        tbl.push_back(mk(1, 16'h0213, 0, 0, 0, 0, 32'h00000213, 2, 24'h100, 24'h102, 1, 0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 32'h00000213, 2, 24'h100, 24'h104, 1, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 32'h0, 0, 24'h104, 24'h104, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            fetch_valid    = tbl[i].fv;
            fetch_data     = tbl[i].fd;
            instr_complete = tbl[i].ic;
            branch         = tbl[i].br;
            branch_target  = tbl[i].bt;
            step();
            chk($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d_instr", i), instr, tbl[i].ei);
            chk($sformatf("row%0d_len", i), 32'(instr_len), 32'(tbl[i].el));
            chk($sformatf("row%0d_pc", i), 32'(pc), 32'(tbl[i].epc));
            chk($sformatf("row%0d_faddr", i), 32'(fetch_addr), 32'(tbl[i].efa));
            chk($sformatf("row%0d_ready", i), 32'(fetch_ready), 32'(tbl[i].erdy));
            chk($sformatf("row%0d_restart", i), 32'(fetch_restart), 32'(tbl[i].ers));
        end
        fetch_valid    = 1'b0;
        instr_complete = 1'b0;
        branch         = 1'b0;

        // Streaming through pointer wrap and pc wrap at the top of memory
        branch        = 1'b1;
        branch_target = 24'hfffff0;
        step();
        branch = 1'b0;
        chk("wrap_branch_pc", 32'(pc), 32'h00fffff0);
        chk("wrap_branch_restart", 32'(fetch_restart), 32'h1);
        step();
        chk("wrap_restart_low", 32'(fetch_restart), 32'h0);
        n      = 10;
        sent   = 0;
        got    = 0;
        exp_pc = 24'hfffff0;
        for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
            if (sent < 2 * n && fetch_ready) begin
                w           = stream_instr(sent / 2);
                fetch_valid = 1'b1;
                fetch_data  = (sent % 2 == 0) ? w[15:0] : w[31:16];
                sent++;
            end else begin
                fetch_valid = 1'b0;
            end
            if (instr_valid) begin
                chk($sformatf("stream_instr%0d", got), instr, stream_instr(got));
                chk($sformatf("stream_pc%0d", got), 32'(pc), 32'(exp_pc));
                instr_complete = 1'b1;
                got++;
                exp_pc = exp_pc + 24'd4;
            end else begin
                instr_complete = 1'b0;
            end
            step();
        end
        fetch_valid    = 1'b0;
        instr_complete = 1'b0;
        chk("stream_count", 32'(got), 32'(n));
        chk("stream_final_pc", 32'(pc), 32'h00000018);
        chk("stream_final_faddr", 32'(fetch_addr), 32'h00000018);
        chk("stream_final_valid", 32'(instr_valid), 32'h0);

        // Mixed-length sequence from address 0
        branch        = 1'b1;
        branch_target = 24'h000000;
        step();
        branch = 1'b0;
        step();
        fetch_valid = 1'b1;
        fetch_data  = 16'h4501; step();
        fetch_data  = 16'h4585; step();
        fetch_data  = 16'h0513; step();
        fetch_data  = 16'h0000; step();
        fetch_valid = 1'b0;
        chk("mix_full_ready", 32'(fetch_ready), 32'h0);
        chk("mix0_instr", instr, 32'h45854501);
        chk("mix0_pc", 32'(pc), 32'h0);
        chk("mix0_valid", 32'(instr_valid), 32'h1);
        instr_complete = 1'b1;
`ifdef TINYQV_IBUF_RVC_EN
        chk("mix0_len", 32'(instr_len), 32'h1);
        step();
        chk("mix1_instr", instr, 32'h05134585);
        chk("mix1_pc", 32'(pc), 32'h2);
        chk("mix1_len", 32'(instr_len), 32'h1);
        chk("mix1_ready", 32'(fetch_ready), 32'h1);
        step();
`else
        chk("mix0_len", 32'(instr_len), 32'h2);
        step();
`endif
        chk("mix2_instr", instr, 32'h00000513);
        chk("mix2_pc", 32'(pc), 32'h4);
        chk("mix2_len", 32'(instr_len), 32'h2);
        step();
        instr_complete = 1'b0;
        chk("mix_end_pc", 32'(pc), 32'h8);
        chk("mix_end_valid", 32'(instr_valid), 32'h0);
        chk("mix_end_faddr", 32'(fetch_addr), 32'h8);

        // Asynchronous reset with half of a 32-bit instruction buffered
        fetch_valid = 1'b1;
        fetch_data  = 16'h0013;
        step();
        fetch_valid = 1'b0;
        chk("pre_rst_instr", instr, 32'h00000013);
        chk("pre_rst_faddr", 32'(fetch_addr), 32'ha);
        #1 rstn = 1'b0;
        #1;
        chk_reset_state("async_rst");
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk_reset_state("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
